// File: rtl/seg_pkg.sv
// Shared segment types and the hex-to-segment pattern table for the scanner.
// Patterns are active-high with bit0 = a ... bit6 = g.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-high seven-segment pattern lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver with frame-synchronous double buffering,
// leading-zero suppression, per-digit dp/blank and PWM brightness.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int  NUM_DIGITS     = 4,
  parameter int  SCAN_DIV       = 1000,
  parameter bit  SEG_ACTIVE_LOW = 1'b1,
  parameter bit  AN_ACTIVE_LOW  = 1'b1,
  localparam int BW             = $clog2(SCAN_DIV + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [BW-1:0]           brightness,
  output logic [6:0]              seg,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    load_ack
);

  localparam int            IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [BW-1:0] CNT_LAST = BW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [BW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, shad_dig_q, shad_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, shad_blank_q, shad_blank_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    wrap_q, wrap_d, ack_q, ack_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_o_q, dp_o_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    load_ack_q, load_ack_d;

  logic                    tick, frame_start;
  logic [NUM_DIGITS-1:0]   supp, cur_onehot;
  logic                    above, cur_dp, cur_blank, cur_supp, lit;
  logic [3:0]              cur_hex;
  seg_t                    cur_seg;

  hex_to_seg u_hex_to_seg (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // Scan timing and buffer handover
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    frame_start  = tick && (idx_q == IDX_LAST);
    cnt_d        = tick ? '0 : cnt_q + BW'(1);
    idx_d        = idx_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    shad_dig_d   = shad_dig_q;
    shad_dp_d    = shad_dp_q;
    shad_blank_d = shad_blank_q;
    ack_d        = 1'b0;
    wrap_d       = frame_start;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    if (frame_start) begin
      // A load landing on the frame-start tick bypasses the pending buffer.
      if (load) begin
        shad_dig_d   = digits;
        shad_dp_d    = dp;
        shad_blank_d = blank;
        pend_vld_d   = 1'b0;
        ack_d        = 1'b1;
      end else if (pend_vld_q) begin
        shad_dig_d   = pend_dig_q;
        shad_dp_d    = pend_dp_q;
        shad_blank_d = pend_blank_q;
        pend_vld_d   = 1'b0;
        ack_d        = 1'b1;
      end
    end else if (load) begin
      pend_dig_d   = digits;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_vld_d   = 1'b1;
    end
  end

  always_comb begin
    supp  = '0;
    above = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above   = above && (shad_dig_q[4*i +: 4] == 4'h0) && !shad_dp_q[i];
      supp[i] = above;
    end
  end

  always_comb begin
    cur_hex    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_supp   = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_hex       = shad_dig_q[4*i +: 4];
        cur_dp        = shad_dp_q[i];
        cur_blank     = shad_blank_q[i];
        cur_supp      = supp[i];
        cur_onehot[i] = 1'b1;
      end
    end
    lit          = !cur_blank && !cur_supp && (cnt_q < brightness);
    seg_d        = (lit ? cur_seg : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
    dp_o_d       = (lit && cur_dp) ^ SEG_ACTIVE_LOW;
    an_d         = (lit ? cur_onehot : '0) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    frame_done_d = wrap_q;
    load_ack_d   = ack_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_vld_q   <= 1'b0;
      shad_dig_q   <= '0;
      shad_dp_q    <= '0;
      shad_blank_q <= '1;
      wrap_q       <= 1'b0;
      ack_q        <= 1'b0;
      seg_q        <= {7{SEG_ACTIVE_LOW}};
      dp_o_q       <= SEG_ACTIVE_LOW;
      an_q         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      shad_dig_q   <= shad_dig_d;
      shad_dp_q    <= shad_dp_d;
      shad_blank_q <= shad_blank_d;
      wrap_q       <= wrap_d;
      ack_q        <= ack_d;
      seg_q        <= seg_d;
      dp_o_q       <= dp_o_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign seg        = seg_q;
  assign dp_o       = dp_o_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign load_ack   = load_ack_q;

endmodule
